// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester/consumer bus bundle for the round-robin mux arbiter
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] data_c;
    logic [WIDTH-1:0] data_d;
    logic [3:0]       ack;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    // Environment side: requesters and the downstream consumer
    modport master (
        output req, data_a, data_b, data_c, data_d, out_ready,
        input  ack, gnt, sel, out_valid, out_data, busy
    );

    // Arbiter side
    modport slave (
        input  req, data_a, data_b, data_c, data_d, out_ready,
        output ack, gnt, sel, out_valid, out_data, busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin 4:1 mux arbiter with per-grant burst limit
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_arbiter_if.slave    bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [3:0]      r_gnt;
    logic [1:0]      r_sel;
    logic [1:0]      r_ptr;
    logic [CW-1:0]   r_burst_cnt;

    state_t          w_state_n;
    logic [3:0]      w_gnt_n;
    logic [1:0]      w_sel_n;
    logic [1:0]      w_ptr_n;
    logic [CW-1:0]   w_burst_cnt_n;

    logic [2:0]      w_arb_idle;
    logic [2:0]      w_arb_rel;
    logic [1:0]      w_sel_inc;
    logic            w_valid;
    logic            w_xfer;
    logic            w_last;
    logic            w_release;
    logic [WIDTH-1:0] w_mux;

    // Returns {found, index}: first set request searching ptr, ptr+1, .. mod 4.
    // Loop runs from the far end so the nearest hit overwrites the rest.
    function automatic logic [2:0] f_arb(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_sel_inc  = r_sel + 2'd1;
    assign w_arb_idle = f_arb(bus.req, r_ptr);
    assign w_arb_rel  = f_arb(bus.req, w_sel_inc);

    // Handshake qualifiers for the currently granted requester
    always_comb begin
        w_valid   = 1'b0;
        w_xfer    = 1'b0;
        w_last    = 1'b0;
        w_release = 1'b0;
        if (r_state == GRANT && !rst) begin
            w_valid   = bus.req[r_sel];
            w_xfer    = w_valid & bus.out_ready;
            w_last    = (r_burst_cnt == CW'(MAX_BURST - 1));
            w_release = !bus.req[r_sel] || (w_xfer && w_last);
        end
    end

    // Full decode of the 4:1 datapath mux
    always_comb begin
        w_mux = '0;
        case (r_sel)
            2'd0:    w_mux = bus.data_a;
            2'd1:    w_mux = bus.data_b;
            2'd2:    w_mux = bus.data_c;
            default: w_mux = bus.data_d;
        endcase
    end

    // Next-state: arbitrate from IDLE, or release and re-arbitrate in the same edge
    always_comb begin
        w_state_n     = r_state;
        w_gnt_n       = r_gnt;
        w_sel_n       = r_sel;
        w_ptr_n       = r_ptr;
        w_burst_cnt_n = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_arb_idle[2]) begin
                    w_state_n     = GRANT;
                    w_sel_n       = w_arb_idle[1:0];
                    w_gnt_n       = 4'b0001 << w_arb_idle[1:0];
                    w_burst_cnt_n = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_n       = w_sel_inc;
                    w_burst_cnt_n = '0;
                    if (w_arb_rel[2]) begin
                        w_sel_n = w_arb_rel[1:0];
                        w_gnt_n = 4'b0001 << w_arb_rel[1:0];
                    end else begin
                        w_state_n = IDLE;
                        w_gnt_n   = 4'b0000;
                    end
                end else if (w_xfer) begin
                    w_burst_cnt_n = r_burst_cnt + CW'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
                w_gnt_n   = 4'b0000;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= 4'b0000;
            r_sel       <= 2'b00;
            r_ptr       <= 2'b00;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_n;
            r_gnt       <= w_gnt_n;
            r_sel       <= w_sel_n;
            r_ptr       <= w_ptr_n;
            r_burst_cnt <= w_burst_cnt_n;
        end
    end

    // Outputs; handshake side is forced quiet while reset is asserted
    always_comb begin
        bus.gnt       = r_gnt;
        bus.sel       = r_sel;
        bus.out_valid = w_valid;
        bus.ack       = w_xfer ? (4'b0001 << r_sel) : 4'b0000;
        bus.out_data  = (r_state == GRANT && !rst) ? w_mux : '0;
        bus.busy      = (r_state == GRANT) && !rst;
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_mux_arbiter_if #(.WIDTH(8)) bus ();

    rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] dv [4];
    int         seq [5];

    initial begin
        total = 0;
        bad   = 0;
        dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'hA5; dv[3] = 8'h44;
        bus.data_a = dv[0]; bus.data_b = dv[1]; bus.data_c = dv[2]; bus.data_d = dv[3];
        bus.out_ready = 1'b1;
        bus.req = 4'b1111;
        rst = 1'b1;

        // 1: reset held two cycles with all requests
        tick();
        chk("t1_gnt_rst", 32'(bus.gnt), 32'h0);
        chk("t1_valid_rst", 32'(bus.out_valid), 32'h0);
        chk("t1_data_rst", 32'(bus.out_data), 32'h0);
        chk("t1_ack_rst", 32'(bus.ack), 32'h0);
        chk("t1_busy_rst", 32'(bus.busy), 32'h0);
        tick();
        chk("t1_gnt_rst2", 32'(bus.gnt), 32'h0);
        chk("t1_sel_rst2", 32'(bus.sel), 32'h0);
        rst = 1'b0;
        tick();
        chk("t1_gnt_a", 32'(bus.gnt), 32'h1);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        chk("t1_data_a", 32'(bus.out_data), 32'h11);

        // 2: sole requester C, burst of 4 then immediate re-grant
        bus.req = 4'b0100;
        do_reset();
        tick();
        chk("t2_gnt", 32'(bus.gnt), 32'h4);
        chk("t2_sel", 32'(bus.sel), 32'h2);
        for (int i = 0; i < 4; i++) begin
            chk("t2_data", 32'(bus.out_data), 32'hA5);
            chk("t2_ack", 32'(bus.ack), 32'h4);
            tick();
        end
        chk("t2_regrant_gnt", 32'(bus.gnt), 32'h4);
        chk("t2_regrant_valid", 32'(bus.out_valid), 32'h1);
        chk("t2_regrant_busy", 32'(bus.busy), 32'h1);

        // 3: all request, rotating 4-transfer bursts A,B,C,D,A
        bus.req = 4'b1111;
        do_reset();
        tick();
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_gnt", 32'(bus.gnt), 32'(4'b0001 << seq[g]));
                chk("t3_sel", 32'(bus.sel), 32'(seq[g]));
                chk("t3_data", 32'(bus.out_data), 32'(dv[seq[g]]));
                chk("t3_ack", 32'(bus.ack), 32'(4'b0001 << seq[g]));
                tick();
            end
        end
        chk("t3_next_b", 32'(bus.gnt), 32'h2);

        // 4: back-pressure on B holds everything and does not count
        bus.req = 4'b0010;
        bus.out_ready = 1'b0;
        do_reset();
        tick();
        bus.req = 4'b0011;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(bus.out_valid), 32'h1);
            chk("t4_hold_data", 32'(bus.out_data), 32'h22);
            chk("t4_hold_gnt", 32'(bus.gnt), 32'h2);
            chk("t4_hold_ack", 32'(bus.ack), 32'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_resume_gnt", 32'(bus.gnt), 32'h2);
            chk("t4_resume_ack", 32'(bus.ack), 32'h2);
            tick();
        end
        chk("t4_after_a", 32'(bus.gnt), 32'h1);

        // 5: A drops request after two transfers, B takes over
        bus.req = 4'b1011;
        do_reset();
        tick();
        chk("t5_gnt_a", 32'(bus.gnt), 32'h1);
        chk("t5_ack1", 32'(bus.ack), 32'h1);
        tick();
        chk("t5_ack2", 32'(bus.ack), 32'h1);
        tick();
        bus.req = 4'b1010;
        #1;
        chk("t5_drop_ack", 32'(bus.ack), 32'h0);
        chk("t5_drop_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("t5_gnt_b", 32'(bus.gnt), 32'h2);
        chk("t5_ack_b", 32'(bus.ack), 32'h2);
        chk("t5_data_b", 32'(bus.out_data), 32'h22);

        // 6: reset in the middle of a C burst
        bus.req = 4'b0100;
        do_reset();
        tick();
        chk("t6_gnt_c", 32'(bus.gnt), 32'h4);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_ack", 32'(bus.ack), 32'h0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_data", 32'(bus.out_data), 32'h0);
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        #1;
        chk("t6_idle_gnt", 32'(bus.gnt), 32'h0);
        chk("t6_idle_busy", 32'(bus.busy), 32'h0);
        chk("t6_idle_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("t6_gnt_a", 32'(bus.gnt), 32'h1);
        chk("t6_sel_a", 32'(bus.sel), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
